// File: rtl/fix_tx_framer.sv
// fix_tx_framer: outbound FIX framer sitting between the engine transmit FIFO
// and the TCP offload engine. It forwards body bytes from a show-ahead FIFO,
// accumulates the FIX CheckSum (body byte sum mod 256), and then appends the
// trailer "10=NNN<DELIM>". Completed frames are counted.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   link_up_i       TOE connection up; only looked at in IDLE
//   fifo_empty_i    FIFO empty
//   fifo_data_i     FIFO head byte (valid when !fifo_empty_i)
//   fifo_last_i     head byte is the final body byte of a message
//   fifo_read_o     pop strobe (combinational)
//   tx_valid_o      tx_data_o holds a byte
//   tx_data_o       outbound byte
//   tx_last_o       byte is the trailer delimiter
//   tx_ready_i      TOE accepts the byte this cycle
//   busy_o          framer is not idle
//   msg_count_o     completed frames, wraps
module fix_tx_framer #(
  parameter logic [7:0] DELIM = 8'h3B,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             link_up_i,
  input  logic             fifo_empty_i,
  input  logic [7:0]       fifo_data_i,
  input  logic             fifo_last_i,
  output logic             fifo_read_o,
  output logic             tx_valid_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_last_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] msg_count_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_BODY, S_T1, S_T0, S_EQ, S_D2, S_D1, S_D0, S_END
  } state_t;

  state_t           state_q;
  logic [7:0]       cs_q;
  logic [3:0]       h_q, t_q, u_q;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;
  logic             tx_last_q;
  logic [CNT_W-1:0] cnt_q;

  logic       slot_free;
  logic       pop;
  logic [7:0] cs_d;
  logic [7:0] h_d, t_d, u_d;

  // The output register can take a new byte when it is empty or being drained.
  assign slot_free = !tx_valid_q || tx_ready_i;
  assign pop       = (state_q == S_BODY) && slot_free && !fifo_empty_i;

  // Checksum including the byte being popped; the digits are only latched when
  // that byte is the last body byte, so they always describe the final sum.
  assign cs_d = cs_q + fifo_data_i;
  assign h_d  = cs_d / 8'd100;
  assign t_d  = (cs_d / 8'd10) % 8'd10;
  assign u_d  = cs_d % 8'd10;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cs_q       <= 8'h00;
      h_q        <= 4'h0;
      t_q        <= 4'h0;
      u_q        <= 4'h0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_last_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cs_q <= 8'h00;
          // The END byte may still be waiting for acceptance here.
          if (slot_free) tx_valid_q <= 1'b0;
          if (link_up_i && !fifo_empty_i) state_q <= S_BODY;
        end
        S_BODY: begin
          if (pop) begin
            tx_data_q  <= fifo_data_i;
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b0;
            cs_q       <= cs_d;
            if (fifo_last_i) begin
              h_q     <= h_d[3:0];
              t_q     <= t_d[3:0];
              u_q     <= u_d[3:0];
              state_q <= S_T1;
            end
          end else if (slot_free) begin
            // FIFO starved: let the pending byte drain, leave a gap.
            tx_valid_q <= 1'b0;
          end
        end
        default: begin
          if (slot_free) begin
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b0;
            case (state_q)
              S_T1: begin tx_data_q <= 8'h31;          state_q <= S_T0; end
              S_T0: begin tx_data_q <= 8'h30;          state_q <= S_EQ; end
              S_EQ: begin tx_data_q <= 8'h3D;          state_q <= S_D2; end
              S_D2: begin tx_data_q <= 8'h30 + {4'h0, h_q}; state_q <= S_D1; end
              S_D1: begin tx_data_q <= 8'h30 + {4'h0, t_q}; state_q <= S_D0; end
              S_D0: begin tx_data_q <= 8'h30 + {4'h0, u_q}; state_q <= S_END; end
              default: begin
                tx_data_q <= DELIM;
                tx_last_q <= 1'b1;
                cnt_q     <= cnt_q + 1'b1;
                state_q   <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign fifo_read_o = pop;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign tx_last_o   = tx_last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign msg_count_o = cnt_q;

endmodule

// File: doc/fix_tx_framer.md
# fix_tx_framer

Outbound FIX framer between the engine's transmit FIFO and the TCP offload engine (TOE).
- Pops message body bytes from a show-ahead FIFO and forwards them to the TOE over a valid/ready byte stream.
- Computes the FIX CheckSum (sum of body bytes mod 256) and appends the trailer `10=NNN<DELIM>` to each message.
- Counts completed messages.

## Interface
Parameters:
- DELIM, 8'h3B, field delimiter byte appended after the checksum digits.
- CNT_W, 16, width of the sent-message counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- link_up_i  in  1  TOE connection established; sampled only in IDLE.
- fifo_empty_i  in  1  FIFO empty.
- fifo_data_i  in  8  FIFO head byte, valid whenever !fifo_empty_i.
- fifo_last_i  in  1  head byte is the final body byte of a message.
- fifo_read_o  out  1  pop strobe; head advances next cycle.
- tx_valid_o  out  1  tx_data_o holds a byte.
- tx_data_o  out  8  outbound byte.
- tx_last_o  out  1  byte is the trailer delimiter (end of frame).
- tx_ready_i  in  1  TOE accepts the byte when tx_valid_o && tx_ready_i.
- busy_o  out  1  state != IDLE.
- msg_count_o  out  CNT_W  completed frames; wraps to 0.

## Operation
- States: IDLE, BODY, T1, T0, EQ, D2, D1, D0, END.
- Output slot free: `!tx_valid_o || tx_ready_i`.
- **IDLE**
  - Go to BODY when link_up_i && !fifo_empty_i.
  - Clear the checksum accumulator cs[7:0] to 0 on entry.
- **BODY**
  - Pop condition: slot free && !fifo_empty_i.
  - On pop, register tx_data_o <= fifo_data_i, set tx_valid_o, and update cs <= cs + fifo_data_i (8-bit, wrapping).
  - If the popped byte has fifo_last_i = 1, go to T1. Also latch the final checksum (including this byte) and its decimal digits: h = cs/100, t = (cs/10)%10, u = cs%10.
- **Trailer states** each load one byte when the slot is free, then advance:
  - T1 loads 8'h31.
  - T0 loads 8'h30.
  - EQ loads 8'h3D.
  - D2 loads 8'h30+h.
  - D1 loads 8'h30+t.
  - D0 loads 8'h30+u.
  - END loads DELIM with tx_last_o = 1.
- When the END byte is loaded, increment msg_count_o and return to IDLE.
- link_up_i falling mid-frame is ignored; the frame completes.
- Body delimiter bytes are ordinary body bytes and are included in cs.
- FIFO empty mid-body: pause in BODY with no pop. tx_valid_o drops once the pending byte is accepted.

## Timing
- Reset values: fifo_read_o=0, tx_valid_o=0, tx_data_o=8'h00, tx_last_o=0, busy_o=0, msg_count_o=0; state IDLE, cs=0.
- Reset mid-frame drops the partial frame immediately. The FIFO is not flushed; remaining bytes of that message become the next frame's body.
- fifo_read_o is combinational from state, fifo_empty_i, tx_valid_o and tx_ready_i. It is never asserted while fifo_empty_i=1 or outside BODY.
- Latency: a popped byte appears on tx_data_o/tx_valid_o the next cycle.
- Entry: IDLE to BODY costs 1 cycle, so the first pop occurs 1 cycle after fifo_empty_i=0 seen in IDLE.
- Throughput: 1 byte/cycle with tx_ready_i=1 and the FIFO non-empty. An N-byte body produces N+7 output bytes in N+7 consecutive cycles.
- The next frame may begin 2 cycles after the END byte is loaded.
- Backpressure: while tx_valid_o && !tx_ready_i, tx_data_o and tx_last_o are held stable, with no pop and no state advance.
- tx_last_o is valid only with tx_valid_o and is cleared when a non-END byte is loaded.

## Test plan
- **Standard body:** body "8=FIX.4.2;" (38 3D 46 49 58 2E 34 2E 32 3B, last on 3B), tx_ready_i=1 -> output is body then 31 30 3D 30 38 39 3B ("10=089;"), with tx_last_o only on the final 3B, 17 consecutive valid cycles, and msg_count_o=1.
- **Checksum wrap:** body FF FF -> cs=254, trailer 31 30 3D 32 35 34 3B. Body 00 -> trailer digits 30 30 30.
- **Backpressure:** tx_ready_i=0 for 5 cycles on the 4th body byte -> tx_data_o is held at 49, fifo_read_o=0 for those cycles, and the output sequence is unchanged.
- **Gating and starvation:** link_up_i=0 with a non-empty FIFO -> no pop, busy_o=0. Separately, FIFO empty for 3 cycles mid-body -> tx_valid_o gaps, and the checksum still yields "10=089;" for the standard body.
- **Reset mid-frame and back-to-back frames:**
  - Assert rst during D1 -> all outputs return to reset values within the same cycle and msg_count_o=0.
  - Two queued standard frames -> two identical trailers and msg_count_o=2.
  - With CNT_W=2, five frames -> msg_count_o=1.
